// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_pkg : shared constants for the 7-segment scan controller              |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package seg7_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hex_to_seg7 : combinational hex nibble to active-low segment decoder       |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_ctrl : multiplexed common-anode 7-segment scanner with blanking  |
// | guard and frame-aligned data swap. Option macro: LEADING_ZERO_BLANK_EN     |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digit_data,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic [6:0]                seg_n,
  output logic                      dp_n,
  output logic [NUM_DIGITS-1:0]     dig_n,
  output logic                      frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [1:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   dig_n_q, dig_n_d;
  logic                    frame_done_q, frame_done_d;
  logic                    copy;
  logic [3:0]              cur_nibble;
  logic [6:0]              dec_seg_n;
  logic [NUM_DIGITS-1:0]   blank_mask;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    copy    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
          copy    = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              copy  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A load coinciding with the frame swap goes straight to the display.
  always_comb begin
    pend_data_d = load ? digit_data : pend_data_q;
    pend_dp_d   = load ? dp_in      : pend_dp_q;
    disp_data_d = copy ? pend_data_d : disp_data_q;
    disp_dp_d   = copy ? pend_dp_d   : disp_dp_q;
  end

  assign cur_nibble = disp_data_d[{idx_d, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (cur_nibble),
    .seg_n  (dec_seg_n)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;
  always_comb begin
    lead_zero  = 1'b1;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lead_zero     = lead_zero && (disp_data_d[4*k +: 4] == 4'h0) && !disp_dp_d[k];
      blank_mask[k] = lead_zero;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Outputs are decoded from next-state values so the registered pins line up with state.
  always_comb begin
    seg_n_d      = SEG_BLANK;
    dp_n_d       = 1'b1;
    dig_n_d      = '1;
    frame_done_d = 1'b0;
    if (state_d == ST_SHOW) begin
      dig_n_d      = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d);
      dp_n_d       = ~disp_dp_d[idx_d];
      frame_done_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
      if (!blank_mask[idx_d]) seg_n_d = dec_seg_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= enable ? ST_BLANK : ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      dig_n_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      dig_n_q      <= dig_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign dig_n      = dig_n_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg7_scan_ctrl : directed + randomized bench with a frame-position model |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        rst, enable, load;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  dig_n;
  logic        frame_done;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .digit_data (digit_data),
    .dp_in      (dp_in),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .dig_n      (dig_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference patterns as {dp, g..a}, active-low.
  logic [7:0] hex_pat [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: position within a frame, plus pending/display contents.
  bit          m_rst, m_run;
  int          p;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pend_dp, m_disp_dp;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit lz_blank(input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 0) return 1'b0;
    for (int j = slot; j < N; j++)
      if (((m_disp >> (4*j)) & 16'hF) != 0 || m_disp_dp[j]) return 1'b0;
    return 1'b1;
`else
    return (slot < 0);
`endif
  endfunction

  task automatic step();
    bit copy;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_dig;
    logic       e_fd;
    int slot, offs, nib;
    @(posedge clk);
    copy = 1'b0;
    if (rst) begin
      m_rst = 1'b1; m_run = enable; p = 0;
      m_pend = '0; m_pend_dp = '0; m_disp = '0; m_disp_dp = '0;
    end else begin
      m_rst = 1'b0;
      if (!enable) begin
        m_run = 1'b0; p = 0;
      end else if (!m_run) begin
        m_run = 1'b1; p = 0; copy = 1'b1;
      end else begin
        p = (p + 1) % FRAME;
        copy = (p == 0);
      end
      if (copy) begin m_disp = m_pend; m_disp_dp = m_pend_dp; end
      if (load) begin
        m_pend = digit_data; m_pend_dp = dp_in;
        if (copy) begin m_disp = digit_data; m_disp_dp = dp_in; end
      end
    end
    e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_fd = 1'b0;
    if (!m_rst && m_run) begin
      slot = p / RD;
      offs = p % RD;
      if (offs >= BC) begin
        nib   = int'((m_disp >> (4*slot)) & 16'hF);
        e_dig = ~(4'b0001 << slot);
        e_dp  = ~m_disp_dp[slot];
        if (!lz_blank(slot)) e_seg = hex_pat[nib][6:0];
      end
      e_fd = (p == FRAME - 1);
    end
    #1;
    chk("seg_n", {25'd0, seg_n}, {25'd0, e_seg});
    chk("dp_n", {31'd0, dp_n}, {31'd0, e_dp});
    chk("dig_n", {28'd0, dig_n}, {28'd0, e_dig});
    chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
  endtask

  task automatic wait_p(input int tgt);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (p != tgt && k < 200);
    if (p != tgt) begin
      n_vec++;
      n_err++;
      $error("FAIL wait_p timeout observed=%0d expected=%0d", p, tgt);
    end
  endtask

  initial begin
    int fd_cnt;
    rst = 1'b1; enable = 1'b1; load = 1'b0; digit_data = '0; dp_in = '0;

    // Reset and first slot after release
    repeat (3) step();
    chk("rst_seg", {25'd0, seg_n}, 32'h7F);
    chk("rst_dig", {28'd0, dig_n}, 32'hF);
    chk("rst_fd", {31'd0, frame_done}, 32'h0);
    rst = 1'b0;
    step();
    chk("slot0_c1_dig", {28'd0, dig_n}, 32'hF);
    step();
    chk("slot0_c2_dig", {28'd0, dig_n}, 32'hE);
    chk("slot0_c2_seg", {25'd0, seg_n}, 32'h40);

    // Load 1234 with dp on digit 2, observe next frame
    load = 1'b1; digit_data = 16'h1234; dp_in = 4'b0100;
    step();
    load = 1'b0;
    wait_p(BC);
    chk("f1234_s0", {25'd0, seg_n}, 32'h19);
    wait_p(RD + BC);
    chk("f1234_s1", {25'd0, seg_n}, 32'h30);
    chk("f1234_d1", {28'd0, dig_n}, 32'hD);
    wait_p(2*RD + BC);
    chk("f1234_s2", {25'd0, seg_n}, 32'h24);
    chk("f1234_dp2", {31'd0, dp_n}, 32'h0);
    wait_p(3*RD + BC);
    chk("f1234_s3", {25'd0, seg_n}, 32'h79);
    chk("f1234_d3", {28'd0, dig_n}, 32'h7);

    // frame_done cadence over two frames
    wait_p(0);
    fd_cnt = 0;
    for (int i = 0; i < 2*FRAME; i++) begin
      step();
      if (frame_done === 1'b1) begin
        fd_cnt++;
        chk("fd_dig", {28'd0, dig_n}, 32'h7);
      end
    end
    chk("fd_count", fd_cnt, 2);

    // Load mid-frame: current frame unaffected
    wait_p(2*RD + BC);
    load = 1'b1; digit_data = 16'hABCD; dp_in = 4'b0000;
    step();
    load = 1'b0;
    wait_p(3*RD + BC);
    chk("abcd_old_s3", {25'd0, seg_n}, 32'h79);
    wait_p(BC);
    chk("abcd_s0", {25'd0, seg_n}, 32'h21);
    wait_p(RD + BC);
    chk("abcd_s1", {25'd0, seg_n}, 32'h46);
    wait_p(2*RD + BC);
    chk("abcd_s2", {25'd0, seg_n}, 32'h03);
    wait_p(3*RD + BC);
    chk("abcd_s3", {25'd0, seg_n}, 32'h08);

    // Enable dropped during SHOW of digit 1, pending copied on restart
    wait_p(RD + BC + 1);
    load = 1'b1; digit_data = 16'h5678; enable = 1'b0;
    step();
    load = 1'b0;
    chk("dis_dig", {28'd0, dig_n}, 32'hF);
    chk("dis_seg", {25'd0, seg_n}, 32'h7F);
    repeat (3) step();
    enable = 1'b1;
    step();
    chk("reen_dig", {28'd0, dig_n}, 32'hF);
    step();
    step();
    chk("reen_s0_dig", {28'd0, dig_n}, 32'hE);
    chk("reen_s0_seg", {25'd0, seg_n}, 32'h00);

    // Leading-zero pattern
    load = 1'b1; digit_data = 16'h0050; dp_in = 4'b0000;
    step();
    load = 1'b0;
    wait_p(BC);
    chk("lz_s0", {25'd0, seg_n}, 32'h40);
    wait_p(RD + BC);
    chk("lz_s1", {25'd0, seg_n}, 32'h12);
    wait_p(2*RD + BC);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_s2", {25'd0, seg_n}, 32'h7F);
    wait_p(3*RD + BC);
    chk("lz_s3", {25'd0, seg_n}, 32'h7F);
`else
    chk("lz_s2", {25'd0, seg_n}, 32'h40);
    wait_p(3*RD + BC);
    chk("lz_s3", {25'd0, seg_n}, 32'h40);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1200; i++) begin
      load = ($urandom_range(0, 7) == 0);
      digit_data = 16'($urandom);
      if ($urandom_range(0, 2) == 0) digit_data = digit_data & 16'h00FF;
      dp_in = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      rst = (i >= 600 && i < 602);
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
